// File: rtl/store_data_align_if.sv
// Store-request and data-memory write port bundle for store_data_align.
// master = EX stage plus memory model side, slave = the alignment unit.
interface store_data_align_if #(
    parameter int ADDR_W = 32
);
    // Handshakes: a store is accepted on a rising clock edge with st_valid & st_ready.
    // A memory beat completes on a rising clock edge with mem_req & mem_ack.
    // mem_req and its payload stay stable until that edge or a timeout.
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic              st_done;
    logic              st_err;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb, st_done, st_err
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb, st_done, st_err
    );
endinterface

// File: rtl/store_data_align.sv
// Aligns store data to byte lanes with write strobes and drives a word-addressed write port.
// Define STORE_SPLIT_EN to split lane-spilling stores into two beats; otherwise they abort.
module store_data_align #(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    store_data_align_if.slave   bus,
    output logic [2:0]          dbgState
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state;
    logic [7:0]  waitCnt;
    logic [31:0] beat1Data;
    logic [3:0]  beat1Strb;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  laneMask;
    logic [63:0] shifted;
    logic        splitAbort;

    always_comb begin
        off = bus.st_addr[1:0];
        unique case (bus.st_size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        laneMask = {4'b0000, mask} << off;
        // Upper word holds the bytes that cross into the next memory word.
        shifted  = {32'd0, bus.st_data} << {off, 3'b000};
`ifdef STORE_SPLIT_EN
        splitAbort = 1'b0;
`else
        splitAbort = |laneMask[7:4];
`endif
    end

    assign bus.st_ready = (state == IDLE);
    assign dbgState     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            waitCnt       <= 8'd0;
            beat1Data     <= 32'd0;
            beat1Strb     <= 4'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            bus.st_done   <= 1'b0;
            bus.st_err    <= 1'b0;
        end else begin
            bus.st_done <= 1'b0;
            bus.st_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.st_valid) begin
                        waitCnt   <= 8'd0;
                        beat1Data <= shifted[63:32];
                        beat1Strb <= laneMask[7:4];
                        if (splitAbort) begin
                            state      <= ERR;
                            bus.st_err <= 1'b1;
                        end else begin
                            state         <= BEAT0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_addr  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_wdata <= shifted[31:0];
                            bus.mem_wstrb <= laneMask[3:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus.mem_ack) begin
                        waitCnt <= 8'd0;
                        // mem_req stays high straight into the second beat.
                        if (state == BEAT0 && |beat1Strb) begin
                            state         <= BEAT1;
                            bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
                            bus.mem_wdata <= beat1Data;
                            bus.mem_wstrb <= beat1Strb;
                        end else begin
                            state       <= DONE;
                            bus.mem_req <= 1'b0;
                            bus.st_done <= 1'b1;
                        end
                    end else if (waitCnt == WAIT_LAST) begin
                        state       <= ERR;
                        bus.mem_req <= 1'b0;
                        bus.st_err  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_data_align.sv
// Bench for store_data_align: directed scenarios plus random stores checked against a byte-placement model.
module tb_store_data_align;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_delay    = 0;
    int ack_wait     = 0;

    logic [67:0] exp_q[$];

    store_data_align_if #(.ADDR_W(32)) bus();

    store_data_align #(.ADDR_W(32), .WAIT_MAX(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbgState (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory responder + beat scoreboard ----------------
    always @(negedge clk) begin
        logic [67:0] exp_b;
        logic [67:0] got_b;
        if (!bus.mem_req) begin
            bus.mem_ack = 1'b0;
            ack_wait    = 0;
        end else begin
            bus.mem_ack = (ack_delay >= 0) && (ack_wait >= ack_delay);
            ack_wait++;
            if (bus.mem_ack) begin
                ack_wait = 0;
                got_b = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_unexpected: got %h required none", got_b);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        tests_failed++;
                        $display("FAIL beat: got addr/data/strb %h required %h", got_b, exp_b);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                  output int nb, output logic [67:0] b0, output logic [67:0] b1);
        logic [31:0] w0;
        logic [31:0] ba;
        logic [31:0] wd [2];
        logic [3:0]  st [2];
        int nbytes;
        int k;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        w0 = {a[31:2], 2'b00};
        wd[0] = 32'd0; wd[1] = 32'd0; st[0] = 4'd0; st[1] = 4'd0;
        // Every data byte is placed by its own byte address; only sized bytes get strobes.
        for (int i = 0; i < 4; i++) begin
            ba = a + 32'(i);
            k  = (ba[31:2] == w0[31:2]) ? 0 : 1;
            wd[k][8*ba[1:0] +: 8] = d[8*i +: 8];
            if (i < nbytes) st[k][ba[1:0]] = 1'b1;
        end
        nb = (st[1] != 4'd0) ? 2 : 1;
        b0 = {w0, wd[0], st[0]};
        b1 = {w0 + 32'd4, wd[1], st[1]};
    endfunction

    // ---------------- driver ----------------
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int dly, input bit hold,
                            output int done_at, output int err_at, output int req_cyc,
                            output int n_done, output int n_err, output bit timed_out,
                            output logic rdy_after);
        int settle;
        done_at = -1; err_at = -1; req_cyc = 0; n_done = 0; n_err = 0;
        timed_out = 1'b1; rdy_after = 1'bx; settle = -1;
        ack_delay = dly;
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_addr = a; bus.st_data = d; bus.st_size = sz;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (hold) bus.st_data = ~d;
            else      bus.st_valid = 1'b0;
            if (bus.mem_req) req_cyc++;
            if (bus.st_done) begin n_done++; if (done_at < 0) done_at = n; end
            if (bus.st_err)  begin n_err++;  if (err_at < 0)  err_at = n;  end
            if (settle < 0 && (bus.st_done || bus.st_err)) begin
                settle = n; bus.st_valid = 1'b0; timed_out = 1'b0;
            end
            if (settle >= 0 && n == settle + 1) rdy_after = bus.st_ready;
            if (settle >= 0 && n == settle + 3) break;
        end
        bus.st_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.st_done, bus.st_err} !== 71'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%b addr=%h wdata=%h wstrb=%b done=%b err=%b required all 0",
                     bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.st_done, bus.st_err);
        end
        tests_run++;
        if (bus.st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b required 1", bus.st_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.st_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: got ready=%b req=%b required 1/0", bus.st_ready, bus.mem_req);
        end
    endtask

    task automatic test_byte;
        int da, ea, rc, nd, ne; bit to; logic ra;
        exp_q.push_back({32'h0000_1000, 32'hAB00_0000, 4'b1000});
        do_store(32'h0000_1003, 32'h0000_00AB, 2'b00, 0, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || da != 2 || nd != 1 || ne != 0) begin
            tests_failed++;
            $display("FAIL byte_latency: got to=%b done_at=%0d dones=%0d errs=%0d required 0/2/1/0", to, da, nd, ne);
        end
        tests_run++;
        if (rc != 1 || ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL byte_req: got req_cycles=%0d ready_after=%b required 1/1", rc, ra);
        end
    endtask

    task automatic test_half_delay;
        int da, ea, rc, nd, ne; bit to; logic ra;
        exp_q.push_back({32'h0000_2000, 32'hBEEF_0000, 4'b1100});
        do_store(32'h0000_2002, 32'h0000_BEEF, 2'b01, 3, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || rc != 4 || da != 5 || nd != 1 || ne != 0) begin
            tests_failed++;
            $display("FAIL half_delay: got to=%b req_cycles=%0d done_at=%0d dones=%0d errs=%0d required 0/4/5/1/0",
                     to, rc, da, nd, ne);
        end
    endtask

    task automatic test_split;
        int da, ea, rc, nd, ne; bit to; logic ra;
`ifdef STORE_SPLIT_EN
        exp_q.push_back({32'h0000_3000, 32'h4400_0000, 4'b1000});
        exp_q.push_back({32'h0000_3004, 32'h0011_2233, 4'b0111});
        do_store(32'h0000_3003, 32'h1122_3344, 2'b10, 0, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || rc != 2 || da != 3 || nd != 1 || ne != 0) begin
            tests_failed++;
            $display("FAIL split: got to=%b req_cycles=%0d done_at=%0d dones=%0d errs=%0d required 0/2/3/1/0",
                     to, rc, da, nd, ne);
        end
`else
        do_store(32'h0000_3003, 32'h1122_3344, 2'b10, 0, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || rc != 0 || ea != 1 || nd != 0 || ne != 1 || ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL split_off: got to=%b req_cycles=%0d err_at=%0d dones=%0d errs=%0d ready=%b required 0/0/1/0/1/1",
                     to, rc, ea, nd, ne, ra);
        end
`endif
    endtask

    task automatic test_wrap;
        int da, ea, rc, nd, ne; bit to; logic ra;
        bit exp_err;
`ifdef STORE_SPLIT_EN
        exp_err = 1'b0;
        exp_q.push_back({32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100});
        exp_q.push_back({32'h0000_0000, 32'h0000_A1B2, 4'b0011});
`else
        exp_err = 1'b1;
`endif
        do_store(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10, 1, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || nd != (exp_err ? 0 : 1) || ne != (exp_err ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL wrap: got to=%b dones=%0d errs=%0d required err=%b", to, nd, ne, exp_err);
        end
    endtask

    task automatic test_size11;
        int da, ea, rc, nd, ne; bit to; logic ra;
        exp_q.push_back({32'h0000_7000, 32'h89AB_CDEF, 4'b1111});
        do_store(32'h0000_7000, 32'h89AB_CDEF, 2'b11, 0, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || da != 2 || nd != 1 || ne != 0) begin
            tests_failed++;
            $display("FAIL size11: got to=%b done_at=%0d dones=%0d errs=%0d required 0/2/1/0", to, da, nd, ne);
        end
    endtask

    task automatic test_timeout;
        int da, ea, rc, nd, ne; bit to; logic ra;
        do_store(32'h0000_4000, 32'h5566_7788, 2'b10, -1, 1'b0, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || rc != 4 || ea != 5 || nd != 0 || ne != 1) begin
            tests_failed++;
            $display("FAIL timeout: got to=%b req_cycles=%0d err_at=%0d dones=%0d errs=%0d required 0/4/5/0/1",
                     to, rc, ea, nd, ne);
        end
        tests_run++;
        if (ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_ready: got %b required 1", ra);
        end
        ack_delay = 0;
    endtask

    task automatic test_ignore_busy;
        int da, ea, rc, nd, ne; bit to; logic ra;
        exp_q.push_back({32'h0000_6000, 32'hCAFE_F00D, 4'b1111});
        do_store(32'h0000_6000, 32'hCAFE_F00D, 2'b10, 2, 1'b1, da, ea, rc, nd, ne, to, ra);
        tests_run++;
        if (to !== 1'b0 || da != 4 || nd != 1 || ne != 0 || ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_busy: got to=%b done_at=%0d dones=%0d errs=%0d ready=%b required 0/4/1/0/1",
                     to, da, nd, ne, ra);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        ack_delay = -1;
        @(negedge clk);
        bus.st_valid = 1'b1; bus.st_addr = 32'h0000_5000; bus.st_data = 32'h1234_5678; bus.st_size = 2'b10;
        @(negedge clk);
        bus.st_valid = 1'b0;
        tests_run++;
        if (bus.mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_req_before: got %b required 1", bus.mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.st_done, bus.st_err} !== 71'd0
            || bus.st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got req=%b addr=%h wdata=%h wstrb=%b ready=%b required 0/0/0/0/1",
                     bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.st_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.st_done || bus.st_err || !bus.st_ready || bus.mem_req) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL mid_after: got %0d bad cycles required 0", stray);
        end
        ack_delay = 0;
    endtask

    task automatic test_random;
        int da, ea, rc, nd, ne, nb; bit to; logic ra;
        logic [31:0] a, d; logic [1:0] sz; int dly;
        logic [67:0] b0, b1;
        bit exp_err;
        for (int it = 0; it < 24; it++) begin
            a   = $urandom;
            d   = $urandom;
            sz  = 2'($urandom_range(0, 3));
            dly = $urandom_range(0, 3);
            model(a, d, sz, nb, b0, b1);
`ifdef STORE_SPLIT_EN
            exp_err = 1'b0;
`else
            exp_err = (nb == 2);
`endif
            if (!exp_err) begin
                exp_q.push_back(b0);
                if (nb == 2) exp_q.push_back(b1);
            end
            do_store(a, d, sz, dly, 1'b0, da, ea, rc, nd, ne, to, ra);
            tests_run++;
            if (to !== 1'b0 || nd != (exp_err ? 0 : 1) || ne != (exp_err ? 1 : 0) || ra !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_%0d: addr=%h size=%0d got to=%b dones=%0d errs=%0d ready=%b required err=%b",
                         it, a, sz, to, nd, ne, ra, exp_err);
            end
        end
    endtask

    task automatic check_drained(input string tag);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing_beats: got %0d pending required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        bus.st_valid = 1'b0; bus.st_addr = 32'd0; bus.st_data = 32'd0; bus.st_size = 2'd0;
        repeat (2) @(negedge clk);
        test_reset;
        test_byte;        check_drained("byte");
        test_half_delay;  check_drained("half");
        test_split;       check_drained("split");
        test_wrap;        check_drained("wrap");
        test_size11;      check_drained("size11");
        test_timeout;     check_drained("timeout");
        test_ignore_busy; check_drained("ignore_busy");
        test_reset_mid;   check_drained("reset_mid");
        test_random;      check_drained("random");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
